// File: rtl/nonce_pkg.sv
// Shared types and constants for the nonce job dispatcher.
// Optional stats outputs are enabled by NONCE_DISPATCH_STATS_EN.
package nonce_pkg;

   localparam int HASH_ID_W  = 4;
   localparam int M_DATA_W   = 96;
   localparam int MIDSTATE_W = 256;
   localparam int JOB_W      = HASH_ID_W + M_DATA_W + MIDSTATE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_HOLD  = 2'b11
   } state_t;

   typedef struct packed {
      logic [HASH_ID_W-1:0]  hash_id;
      logic [M_DATA_W-1:0]   m_data;
      logic [MIDSTATE_W-1:0] initial_h;
   } job_t;

endpackage

// File: rtl/nonce_rr_pick.sv
// Round-robin finder: first set mask bit at or after ptr, wrapping.
// Combinational; grant is one-hot, any flags a hit.
module nonce_rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && mask[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = PW'(j);
         end
      end
   end

endmodule

// File: rtl/nonce_job_dispatcher.sv
// Queues SPI jobs and issues each to an idle nonce core, round-robin.
// Define NONCE_DISPATCH_STATS_EN for dispatch_cnt / drop_cnt outputs.
module nonce_job_dispatcher
   import nonce_pkg::*;
#(
   parameter int N_CORES = 4,
   parameter int DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [HASH_ID_W-1:0]  wr_hash_id,
   input  logic [M_DATA_W-1:0]   wr_m_data,
   input  logic [MIDSTATE_W-1:0] wr_initial_h,
   input  logic                  flush,
   input  logic [N_CORES-1:0]    core_busy,
   output logic [N_CORES-1:0]    start,
   output logic [HASH_ID_W-1:0]  hash_id,
   output logic [M_DATA_W-1:0]   m_data,
   output logic [MIDSTATE_W-1:0] initial_h,
   output logic [1:0]            jobs_pending
`ifdef NONCE_DISPATCH_STATS_EN
   ,
   output logic [15:0]           dispatch_cnt,
   output logic [7:0]            drop_cnt
`endif
);

   localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   job_t                mem [DEPTH];
   job_t                bus_q;
   logic [AW-1:0]       wp;
   logic [AW-1:0]       rp;
   logic [CW-1:0]       count;
   logic [PW-1:0]       rr_ptr;
   logic [N_CORES-1:0]  start_q;
   logic [N_CORES-1:0]  reserved_q;
   logic [N_CORES-1:0]  grant;
   logic [PW-1:0]       pick_idx;
   logic                pick_any;
   logic                wr_en;
   logic                pop;
   state_t              state;

   assign wr_ready     = (count != CW'(DEPTH));
   assign wr_en        = wr_valid && wr_ready && !flush;
   assign pop          = (state == ST_IDLE) && (count != '0)
                         && pick_any && !flush;
   assign jobs_pending = 2'(count);
   assign hash_id      = bus_q.hash_id;
   assign m_data       = bus_q.m_data;
   assign initial_h    = bus_q.initial_h;

   // flush must also kill a pulse that is already on the wire
   assign start = start_q & {N_CORES{~flush}};

   nonce_rr_pick #(
      .N  (N_CORES),
      .PW (PW)
   ) u_pick (
      .mask  (~core_busy & ~reserved_q),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem[wp] <= job_t'({wr_hash_id, wr_m_data, wr_initial_h});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         rr_ptr     <= '0;
         start_q    <= '0;
         reserved_q <= '0;
         bus_q      <= '0;
         state      <= ST_IDLE;
      end else if (flush) begin
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         start_q    <= '0;
         reserved_q <= '0;
         state      <= ST_IDLE;
      end else begin
         reserved_q <= start_q;
         if (wr_en) wp <= wp + 1'b1;
         if (pop)   rp <= rp + 1'b1;
         count <= count + CW'(wr_en) - CW'(pop);
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  bus_q   <= mem[rp];
                  start_q <= grant;
                  rr_ptr  <= (pick_idx == PW'(N_CORES - 1)) ?
                             '0 : pick_idx + 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               start_q <= '0;
               state   <= ST_HOLD;
            end
            ST_HOLD: begin
               state <= ST_IDLE;
            end
            default: begin
               start_q <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef NONCE_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dispatch_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         if (|start) dispatch_cnt <= dispatch_cnt + 16'd1;
         if (wr_valid && !wr_ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nonce_job_dispatcher.sv
// Bench for nonce_job_dispatcher: directed scenarios plus random traffic
// compared against a queue-based job scheduling model.
module tb_nonce_job_dispatcher;
   import nonce_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [3:0]   wr_hash_id = '0;
   logic [95:0]  wr_m_data = '0;
   logic [255:0] wr_initial_h = '0;
   logic         flush = 1'b0;
   logic [3:0]   core_busy = '0;
   logic [3:0]   start;
   logic [3:0]   hash_id;
   logic [95:0]  m_data;
   logic [255:0] initial_h;
   logic [1:0]   jobs_pending;
`ifdef NONCE_DISPATCH_STATS_EN
   logic [15:0]  dispatch_cnt;
   logic [7:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   nonce_job_dispatcher #(.N_CORES(4), .DEPTH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_hash_id   (wr_hash_id),
      .wr_m_data    (wr_m_data),
      .wr_initial_h (wr_initial_h),
      .flush        (flush),
      .core_busy    (core_busy),
      .start        (start),
      .hash_id      (hash_id),
      .m_data       (m_data),
      .initial_h    (initial_h),
      .jobs_pending (jobs_pending)
`ifdef NONCE_DISPATCH_STATS_EN
      ,
      .dispatch_cnt (dispatch_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   // reference model: job queue, issue timing, round-robin pointer
   job_t       q[$];
   job_t       bus;
   bit         iss;
   int         iss_k;
   int         cool;
   int         rr;
   logic [3:0] res;
   logic [3:0] cur_start;
   bit         acc;
   int         m_disp;
   int         m_drop;
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      bus    = '0;
      iss    = 0;
      iss_k  = 0;
      cool   = 0;
      rr     = 0;
      res    = '0;
      acc    = 0;
      m_disp = 0;
      m_drop = 0;
   endtask

   task automatic model_update();
      logic [3:0] elig;
      bit can;
      if (wr_valid && q.size() >= 2 && m_drop < 255) m_drop++;
      if (cur_start != 4'b0) m_disp = (m_disp + 1) % 65536;
      acc = 0;
      if (flush) begin
         q.delete();
         iss  = 0;
         cool = 0;
      end else begin
         acc  = wr_valid && (q.size() < 2);
         can  = !iss && cool == 0 && q.size() > 0;
         elig = ~core_busy & ~res;
         cool = iss ? 1 : 0;
         iss  = 0;
         if (can && elig != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
               if (elig[(rr + i) % 4]) begin
                  iss_k = (rr + i) % 4;
                  break;
               end
            end
            bus = q.pop_front();
            rr  = (iss_k + 1) % 4;
            iss = 1;
         end
         if (acc)
            q.push_back(job_t'({wr_hash_id, wr_m_data, wr_initial_h}));
      end
      res = cur_start;
   endtask

   task automatic step();
      #1;
      cur_start = (iss && !flush) ? 4'(1 << iss_k) : 4'b0;
      check("start", start, cur_start);
      check("wr_ready", wr_ready, q.size() < 2);
      check("jobs_pending", jobs_pending, q.size());
      check("hash_id", hash_id, bus.hash_id);
      check("m_data", m_data, bus.m_data);
      check("initial_h", initial_h, bus.initial_h);
`ifdef NONCE_DISPATCH_STATS_EN
      check("dispatch_cnt", dispatch_cnt, m_disp);
      check("drop_cnt", drop_cnt, m_drop);
`endif
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic rand_job();
      wr_hash_id = 4'($urandom);
      wr_m_data  = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 8; i++) wr_initial_h[i*32 +: 32] = $urandom;
   endtask

   task automatic push(input int max);
      wr_valid = 1'b1;
      rand_job();
      for (int n = 0; n < max; n++) begin
         step();
         if (acc) break;
      end
      check("push_accept", acc, 1'b1);
      wr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      flush    = 1'b0;
      #1;
      check("rst_start", start, 4'b0);
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_pending", jobs_pending, 2'd0);
      check("rst_hash_id", hash_id, 4'd0);
      check("rst_m_data", m_data, 96'd0);
      check("rst_initial_h", initial_h, 256'd0);
`ifdef NONCE_DISPATCH_STATS_EN
      check("rst_dispatch_cnt", dispatch_cnt, 16'd0);
      check("rst_drop_cnt", drop_cnt, 8'd0);
`endif
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // single job, all cores idle
      core_busy  = 4'b0000;
      rand_job();
      wr_hash_id = 4'd3;
      wr_valid   = 1'b1;
      step();
      wr_valid = 1'b0;
      step();
      check("t1_start", start, 4'b0001);
      check("t1_hash_id", hash_id, 4'd3);
      repeat (4) step();

      // back-to-back writes fill the FIFO
      for (int i = 0; i < 4; i++) push(10);
      repeat (14) step();

      // partially busy array, then fully busy
      do_reset();
      core_busy = 4'b1011;
      push(4);
      repeat (4) step();
      core_busy = 4'b1111;
      push(4);
      repeat (8) step();
      check("t3_pending", jobs_pending, 2'd1);
      core_busy = 4'b1110;
      repeat (5) step();

      // flush while a start is on the wire
      core_busy = 4'b1111;
      push(4);
      push(4);
      core_busy = 4'b0000;
      step();
      flush    = 1'b1;
      wr_valid = 1'b1;
      rand_job();
      step();
      flush    = 1'b0;
      wr_valid = 1'b0;
      check("t4_pending", jobs_pending, 2'd0);
      repeat (4) step();

      // busy lag: core 0 only, raises busy late
      core_busy = 4'b1111;
      push(4);
      push(4);
      core_busy = 4'b1110;
      repeat (3) step();
      core_busy = 4'b1111;
      repeat (6) step();
      core_busy = 4'b0000;
      repeat (6) step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         wr_valid  = 1'($urandom % 2);
         rand_job();
         flush     = ($urandom % 20) == 0;
         core_busy = 4'($urandom);
         step();
      end

      // asynchronous reset in mid-operation
      do_reset();
      for (int n = 0; n < 100; n++) begin
         wr_valid  = 1'($urandom % 2);
         rand_job();
         flush     = ($urandom % 25) == 0;
         core_busy = 4'($urandom) & 4'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
